// File: rtl/tcb_pkg.sv
// Shared TCB types: the subordinate response-stage record and the
// backpressure FSM state encoding.
package tcb_pkg;

    localparam int TCB_DLY_MAX = 4;
    localparam int TCB_DBW     = 32;

    typedef struct packed {
        logic               vld;
        logic [TCB_DBW-1:0] rdt;
        logic               err;
    } tcb_sub_rsp_t;

    localparam tcb_sub_rsp_t TCB_SUB_RSP_IDLE = '{vld: 1'b0, rdt: {TCB_DBW{1'b0}}, err: 1'b0};

    typedef enum logic [1:0] {
        BPR_IDLE  = 2'd0,
        BPR_WAIT  = 2'd1,
        BPR_READY = 2'd2
    } tcb_bpr_state_t;

endpackage

// File: rtl/tcb_sub_bpr.sv
// Programmable backpressure for the TCB subordinate: rdy is held low for BPR
// cycles once a request shows up, then raised for exactly one cycle.
module tcb_sub_bpr
    import tcb_pkg::*;
#(
    parameter int BPR = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    output logic rdy
);

    if (BPR == 0) begin : g_always_ready
        logic unused_s;
        assign unused_s = ^{clk, rst, vld};
        assign rdy      = 1'b1;
    end else begin : g_fsm
        localparam int CW = $clog2(BPR + 1);
        localparam logic [CW-1:0] CNT_LOAD = CW'(BPR - 1);

        tcb_bpr_state_t  state_r, state_s;
        logic [CW-1:0]   cnt_r, cnt_s;
        logic            rdy_r;

        // Next-state logic; the cycle in IDLE that sees vld is the first low cycle.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            case (state_r)
                BPR_IDLE: begin
                    if (vld) begin
                        if (BPR == 1) begin
                            state_s = BPR_READY;
                        end else begin
                            state_s = BPR_WAIT;
                            cnt_s   = CNT_LOAD;
                        end
                    end else begin
                        state_s = BPR_IDLE;
                    end
                end
                BPR_WAIT: begin
                    cnt_s = cnt_r - CW'(1);
                    if (cnt_r <= CW'(1)) begin
                        state_s = BPR_READY;
                    end else begin
                        state_s = BPR_WAIT;
                    end
                end
                BPR_READY: begin
                    state_s = BPR_IDLE;
                end
                default: begin
                    state_s = BPR_IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end

        // State, counter and registered ready.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= BPR_IDLE;
                cnt_r   <= {CW{1'b0}};
                rdy_r   <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                rdy_r   <= (state_s == BPR_READY);
            end
        end

        assign rdy = rdy_r;
    end

endmodule

// File: rtl/tcb_sub_mem.sv
// TCB subordinate memory: byte-enable writes, full-word reads, fixed DLY-cycle
// response pipeline and error response for out-of-range or misaligned requests.
module tcb_sub_mem
    import tcb_pkg::*;
#(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8,
    parameter int DLY = 1,
    parameter int SIZ = 4096,
    parameter int BPR = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tcb_vld,
    output logic           tcb_rdy,
    input  logic           tcb_wen,
    input  logic [ABW-1:0] tcb_adr,
    input  logic [DBW/SLW-1:0] tcb_ben,
    input  logic [DBW-1:0] tcb_wdt,
    output logic [DBW-1:0] tcb_rdt,
    output logic           tcb_err
);

    localparam int BEW = DBW / SLW;
    localparam int IAW = $clog2(SIZ);
    localparam int OFW = $clog2(BEW);
    localparam int DEP = SIZ / BEW;

    if (DLY < 1 || DLY > TCB_DLY_MAX) begin : g_chk_dly
        $fatal(1, "tcb_sub_mem: DLY must be within 1..TCB_DLY_MAX");
    end
    if ((SIZ & (SIZ - 1)) != 0 || (SIZ % BEW) != 0) begin : g_chk_siz
        $fatal(1, "tcb_sub_mem: SIZ must be a power of two and a multiple of BEW");
    end
    if ((DBW % SLW) != 0 || DBW != TCB_DBW) begin : g_chk_dbw
        $fatal(1, "tcb_sub_mem: DBW must be a multiple of SLW and match TCB_DBW");
    end

    logic                 trn_s;
    logic                 err_req_s;
    logic                 wr_s;
    logic [IAW-OFW-1:0]   idx_s;
    logic [DBW-1:0]       mem_r [DEP];
    tcb_sub_rsp_t         rsp_in_s;
    tcb_sub_rsp_t         pipe_r [DLY];

    tcb_sub_bpr #(.BPR(BPR)) u_bpr (
        .clk (clk),
        .rst (rst),
        .vld (tcb_vld),
        .rdy (tcb_rdy)
    );

    assign trn_s = tcb_vld & tcb_rdy;
    assign idx_s = tcb_adr[IAW-1:OFW];
    // Full-width compare so high address bits can never alias into the array.
    assign err_req_s = (64'(tcb_adr) >= 64'(SIZ))
                     || ((tcb_adr & ABW'(BEW - 1)) != {ABW{1'b0}});
    assign wr_s = trn_s & tcb_wen & ~err_req_s;

    // Byte-enabled write port; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            for (int b = 0; b < BEW; b++) begin
                if (tcb_ben[b]) begin
                    mem_r[idx_s][b*SLW +: SLW] <= tcb_wdt[b*SLW +: SLW];
                end
            end
        end
    end

    // Stage-0 record for this cycle's transfer; idle record when there is none.
    always_comb begin
        rsp_in_s = TCB_SUB_RSP_IDLE;
        if (trn_s) begin
            rsp_in_s.vld = 1'b1;
            rsp_in_s.err = err_req_s;
            if (!tcb_wen && !err_req_s) begin
                rsp_in_s.rdt = mem_r[idx_s];
            end else begin
                rsp_in_s.rdt = {DBW{1'b0}};
            end
        end else begin
            rsp_in_s = TCB_SUB_RSP_IDLE;
        end
    end

    // Response shift register: no stall, reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) begin
                pipe_r[i] <= TCB_SUB_RSP_IDLE;
            end
        end else begin
            pipe_r[0] <= rsp_in_s;
            for (int i = 1; i < DLY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tcb_rdt = pipe_r[DLY-1].vld ? pipe_r[DLY-1].rdt : {DBW{1'b0}};
    assign tcb_err = pipe_r[DLY-1].vld & pipe_r[DLY-1].err;

endmodule

// File: tb/tb_tcb_sub_mem.sv
// Bench for tcb_sub_mem: three instances (DLY/BPR = 1/0, 3/0, 2/2) driven in
// lockstep and compared every cycle against a transaction-level model.
module tb_tcb_sub_mem;

    localparam int N   = 3;
    localparam int SIZ = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld_s [N];
    logic        wen_s [N];
    logic [31:0] adr_s [N];
    logic [3:0]  ben_s [N];
    logic [31:0] wdt_s [N];
    logic        rdy_s [N];
    logic [31:0] rdt_s [N];
    logic        err_s [N];

    always #5 clk = ~clk;

    tcb_sub_mem #(.DLY(1), .BPR(0)) dut0 (
        .clk(clk), .rst(rst), .tcb_vld(vld_s[0]), .tcb_rdy(rdy_s[0]), .tcb_wen(wen_s[0]),
        .tcb_adr(adr_s[0]), .tcb_ben(ben_s[0]), .tcb_wdt(wdt_s[0]), .tcb_rdt(rdt_s[0]), .tcb_err(err_s[0]));
    tcb_sub_mem #(.DLY(3), .BPR(0)) dut1 (
        .clk(clk), .rst(rst), .tcb_vld(vld_s[1]), .tcb_rdy(rdy_s[1]), .tcb_wen(wen_s[1]),
        .tcb_adr(adr_s[1]), .tcb_ben(ben_s[1]), .tcb_wdt(wdt_s[1]), .tcb_rdt(rdt_s[1]), .tcb_err(err_s[1]));
    tcb_sub_mem #(.DLY(2), .BPR(2)) dut2 (
        .clk(clk), .rst(rst), .tcb_vld(vld_s[2]), .tcb_rdy(rdy_s[2]), .tcb_wen(wen_s[2]),
        .tcb_adr(adr_s[2]), .tcb_ben(ben_s[2]), .tcb_wdt(wdt_s[2]), .tcb_rdt(rdt_s[2]), .tcb_err(err_s[2]));

    typedef struct {
        logic        vld;
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    req_t        reqq [N][$];
    rsp_t        rspq [N][$];
    req_t        cur  [N];
    logic [31:0] mdl_mem [int];
    bit          pend  [N];
    bit          busy  [N];
    int          start [N];
    int          cyc;
    int          n_checks;
    int          n_fail;

    function automatic int dly_of(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int bpr_of(int k);
        return (k == 2) ? 2 : 0;
    endfunction

    task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(int k, bit v, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        req_t r;
        r.vld = v; r.wen = w; r.adr = a; r.ben = b; r.wdt = d;
        reqq[k].push_back(r);
    endtask

    task automatic push_all(bit v, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        for (int k = 0; k < N; k++) push(k, v, w, a, b, d);
    endtask

    // Apply one accepted transfer to the model and queue its response.
    task automatic model_trn(int k, req_t r);
        rsp_t        s;
        int          key;
        logic [31:0] w;
        bit          err;
        err   = (r.adr >= 32'(SIZ)) || ((r.adr % 32'd4) != 32'd0);
        key   = k * (SIZ / 4) + int'(r.adr / 32'd4);
        s.due = cyc + dly_of(k);
        s.err = err;
        s.rdt = 32'd0;
        if (!err) begin
            if (!r.wen) begin
                s.rdt = mdl_mem[key];
            end else begin
                w = mdl_mem.exists(key) ? mdl_mem[key] : 32'hxxxx_xxxx;
                for (int b = 0; b < 4; b++) begin
                    if (r.ben[b]) w[b*8 +: 8] = r.wdt[b*8 +: 8];
                end
                mdl_mem[key] = w;
            end
        end
        rspq[k].push_back(s);
    endtask

    // One clock: drive inputs, check all outputs, account for transfers.
    task automatic step();
        logic        exp_rdy;
        logic [31:0] exp_rdt;
        logic        exp_err;
        rsp_t        s;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (!pend[k]) begin
                if (reqq[k].size() > 0) cur[k] = reqq[k].pop_front();
                else cur[k].vld = 1'b0;
                vld_s[k] = cur[k].vld;
                wen_s[k] = cur[k].wen;
                adr_s[k] = cur[k].adr;
                ben_s[k] = cur[k].ben;
                wdt_s[k] = cur[k].wdt;
                pend[k]  = cur[k].vld;
            end
            if (bpr_of(k) == 0) begin
                exp_rdy = 1'b1;
            end else begin
                if (!busy[k] && vld_s[k]) begin
                    busy[k]  = 1'b1;
                    start[k] = cyc;
                end
                exp_rdy = busy[k] && (cyc == start[k] + bpr_of(k));
            end
            check_eq($sformatf("dut%0d rdy", k), 64'(rdy_s[k]), 64'(exp_rdy));
            exp_rdt = 32'd0;
            exp_err = 1'b0;
            if (rspq[k].size() > 0 && rspq[k][0].due == cyc) begin
                s = rspq[k].pop_front();
                exp_rdt = s.rdt;
                exp_err = s.err;
            end
            check_eq($sformatf("dut%0d rdt", k), 64'(rdt_s[k]), 64'(exp_rdt));
            check_eq($sformatf("dut%0d err", k), 64'(err_s[k]), 64'(exp_err));
            if (vld_s[k] && exp_rdy) begin
                model_trn(k, cur[k]);
                pend[k] = 1'b0;
            end
            if (bpr_of(k) != 0 && busy[k] && cyc == start[k] + bpr_of(k)) busy[k] = 1'b0;
        end
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            vld_s[k] = 1'b0;
            pend[k]  = 1'b0;
            busy[k]  = 1'b0;
            rspq[k].delete();
            reqq[k].delete();
        end
        for (int c = 0; c <= cycles; c++) begin
            if (c == 0) #1;
            else begin
                @(negedge clk);
                cyc++;
            end
            for (int k = 0; k < N; k++) begin
                check_eq($sformatf("dut%0d rst rdy", k), 64'(rdy_s[k]), (bpr_of(k) == 0) ? 64'd1 : 64'd0);
                check_eq($sformatf("dut%0d rst rdt", k), 64'(rdt_s[k]), 64'd0);
                check_eq($sformatf("dut%0d rst err", k), 64'(err_s[k]), 64'd0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic drain(int budget);
        int left;
        int n;
        n = 0;
        do begin
            step();
            n++;
            left = 0;
            for (int k = 0; k < N; k++) left += reqq[k].size() + rspq[k].size() + int'(pend[k]);
        end while (left != 0 && n < budget);
        check_eq("drain", 64'(left), 64'd0);
    endtask

    function automatic logic [31:0] rand_adr();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
            1:       return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            2:       return 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
            3:       return 32'h0000_0FFC;
            default: return 32'($urandom_range(0, 15)) << 2;
        endcase
    endfunction

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        for (int k = 0; k < N; k++) begin
            vld_s[k] = 1'b0; wen_s[k] = 1'b0; adr_s[k] = 32'd0; ben_s[k] = 4'd0; wdt_s[k] = 32'd0;
            pend[k] = 1'b0; busy[k] = 1'b0; start[k] = 0;
        end
        do_reset(2);

        // Preload words 0..15 (first four hold 1..4) and the top word.
        for (int i = 0; i < 16; i++)
            push_all(1'b1, 1'b1, 32'(i * 4), 4'hF, (i < 4) ? 32'(i + 1) : $urandom);
        push_all(1'b1, 1'b1, 32'h0000_0FFC, 4'hF, 32'hA5A5_5A5A);
        push_all(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        push_all(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'd0);
        push_all(1'b1, 1'b1, 32'h0000_0010, 4'h2, 32'h0000_AA00);
        push_all(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        push_all(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        for (int i = 0; i < 4; i++) push_all(1'b1, 1'b0, 32'(i * 4), 4'hF, 32'd0);
        push_all(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'd0);
        push_all(1'b1, 1'b1, 32'h0000_0002, 4'hF, 32'hFFFF_FFFF);
        push_all(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'd0);
        push_all(1'b1, 1'b1, 32'h1000_0004, 4'hF, 32'hFFFF_FFFF);
        push_all(1'b1, 1'b0, 32'h0000_0004, 4'hF, 32'd0);
        push_all(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'd0);
        drain(400);

        // Reset with reads in flight; memory contents must survive.
        push_all(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        push_all(1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'd0);
        step();
        step();
        do_reset(2);
        for (int c = 0; c < 5; c++) step();
        push_all(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        drain(50);

        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 300; i++)
                push(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_adr(),
                     4'($urandom_range(0, 15)), $urandom);
        end
        drain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tcb_sub_mem.md
Name: tcb_sub_mem

Overview:
- Synthesizable TCB subordinate: the responder end of the TCB handshake that the manager and monitor models drive and observe.
- Byte-addressable memory with a fixed response delay DLY, byte-enable writes, and optional programmable backpressure on rdy.
- Error response for out-of-range or misaligned requests.
- Serves as an RTL target behind interconnect in system benches and as a reference subordinate for protocol regression.

Parameters:
ABW, 32, address bus width
DBW, 32, data bus width
SLW, 8, byte (slice) width; BEW = DBW/SLW derived localparam
DLY, 1, response delay in cycles after transfer, legal 1..4
SIZ, 4096, memory size in bytes, power of two, multiple of BEW
BPR, 0, backpressure cycles inserted before each transfer (0 = always ready)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
tcb_vld  input  1  request valid
tcb_rdy  output  1  request ready
tcb_wen  input  1  write enable (1=write, 0=read)
tcb_adr  input  ABW  byte address
tcb_ben  input  BEW  byte enables
tcb_wdt  input  DBW  write data
tcb_rdt  output  DBW  read data, valid DLY cycles after transfer
tcb_err  output  1  error response, valid DLY cycles after transfer

Behaviour:
- Interface: one clock `clk`; reset `rst` asynchronous active-high, asserted asynchronously; all flops clear on its rising edge.
- Transfer: trn = tcb_vld & tcb_rdy, sampled on posedge clk.
- Ready, BPR==0: tcb_rdy tied 1, including during reset.
- Ready, BPR>0: registered FSM, reset state IDLE, tcb_rdy=0.
  - IDLE: tcb_vld=1 -> load counter=BPR-1, go WAIT.
  - WAIT: decrement each cycle; at 0 -> READY.
  - READY: tcb_rdy=1 for exactly one cycle; trn occurs -> IDLE.
  - tcb_vld dropping in WAIT is a manager protocol violation; FSM continues regardless. Counter width = $clog2(BPR+1).
- Decode: idx = adr[$clog2(SIZ)-1:$clog2(BEW)].
  - err_req = (adr >= SIZ) | (adr[$clog2(BEW)-1:0] != 0).
  - Upper address bits are compared, never truncated.
- Write (trn & wen & ~err_req): bytes b with ben[b]=1 take wdt[b*SLW+:SLW]; other bytes unchanged.
- Write with err_req: memory unchanged.
- Read (trn & ~wen): full word at idx is read, regardless of ben; ben is ignored for reads.
- Response pipeline, DLY stages of {vld, rdt, err}:
  - Stage 0 loads on trn; later stages shift every cycle; no stall (TCB has no response backpressure).
  - Last stage drives tcb_rdt/tcb_err when its vld=1. When vld=0: tcb_rdt=0, tcb_err=0.
  - Write response: tcb_rdt=0, tcb_err=err_req.
  - Read response with error: tcb_rdt=0, tcb_err=1.
- Full throughput: back-to-back transfers (BPR==0) produce back-to-back responses, each exactly DLY cycles after its trn.
- Read-after-write: a write at cycle N is visible to a read transferred at cycle N+1. A same-cycle collision is impossible (one transfer per cycle).
- Reset values: tcb_rdy = 1 (BPR==0) or 0 (BPR>0); tcb_rdt=0; tcb_err=0; pipeline vld all 0; FSM IDLE.
- Reset mid-operation: in-flight responses discarded; memory array not reset (contents X after power-up).
- Elaboration-time checks: fatal if DLY not in 1..4, SIZ not a power of two, or DBW%SLW != 0.

Decomposition:
- tcb_pkg: add tcb_sub_rsp_t (packed {vld, rdt, err}, parameterized via localparam widths).
- tcb_pkg: add TCB_DLY_MAX=4 constant.
- Sub-module tcb_sub_bpr: backpressure FSM plus counter, outputs rdy, parameter BPR.
- Memory array, decode and response pipeline stay in tcb_sub_mem.

Test Plan:
- DLY=1, BPR=0: write adr=0x10 wdt=0xDEADBEEF ben=0xF, then read 0x10 -> tcb_rdt=0xDEADBEEF, err=0, 1 cycle after read trn.
- Partial write: ben=0x2, wdt=0x0000AA00 to 0x10 after above, read -> 0xDEADAAEF.
- DLY=3, BPR=0: 4 back-to-back reads of 0x0,0x4,0x8,0xC preloaded 1..4 -> rdt 1,2,3,4 on consecutive cycles starting 3 cycles after first trn; rdy never low.
- BPR=2: read with vld held -> rdy low 2 cycles, high the third; trn on cycle 3; response DLY after trn.
- Errors: read adr=0x1000 (SIZ=4096) -> err=1, rdt=0. Write to 0x0002 -> err=1, and a re-read of 0x0 shows memory unchanged.
- Reset asserted with 2 reads in flight (DLY=3) -> tcb_err/tcb_rdt stay 0, no response after deassert; subsequent read of a previously written word returns the stored value.
